// File: rtl/adder_disp_pkg.sv
// Shared types and constants for the adder / BCD / seven-segment display controller.
//   scan_state_e : display scan FSM states
//   operand_t    : operand pair captured on the load handshake
//   SEG_OFF      : all segments dark in the decoder's active-high gfedcba domain
//   cnt_width()  : slot-counter width for a given refresh / blanking length
package adder_disp_pkg;

    localparam int unsigned OPND_W  = 4;
    localparam int unsigned SUM_W   = 5;
    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned SEG_W   = 7;
    localparam int unsigned AN_W    = 2;

    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_SHOW_ONES = 3'd1,
        ST_GAP_A     = 3'd2,
        ST_SHOW_TENS = 3'd3,
        ST_GAP_B     = 3'd4
    } scan_state_e;

    typedef struct packed {
        logic [OPND_W-1:0] a;
        logic [OPND_W-1:0] b;
    } operand_t;

    localparam logic [SEG_W-1:0] SEG_OFF = 7'h00;

    // Width able to hold 0..max(refresh_div, blank_cycles)-1, never below 1 bit.
    function automatic int unsigned cnt_width(input int unsigned refresh_div,
                                              input int unsigned blank_cycles);
        int unsigned m;
        m = (refresh_div > blank_cycles) ? refresh_div : blank_cycles;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/adder.sv
// Combinational 4-bit adder with a 5-bit zero-extended result.
//   a, b  : operands
//   sum_c : a + b
module adder
    import adder_disp_pkg::*;
(
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    output logic [SUM_W-1:0]  sum_c
);

    assign sum_c = SUM_W'(a) + SUM_W'(b);

endmodule

// File: rtl/binary_to_bcd.sv
// Combinational split of a 0..31 binary value into tens / ones BCD digits.
//   bin    : binary input
//   tens_c : tens digit
//   ones_c : ones digit
module binary_to_bcd
    import adder_disp_pkg::*;
(
    input  logic [SUM_W-1:0]   bin,
    output logic [DIGIT_W-1:0] tens_c,
    output logic [DIGIT_W-1:0] ones_c
);

    // Repeated-subtraction by 10; three steps cover the whole 5-bit range.
    always_comb begin
        tens_c = '0;
        ones_c = DIGIT_W'(bin);
        if (bin >= SUM_W'(30)) begin
            tens_c = DIGIT_W'(3);
            ones_c = DIGIT_W'(bin - SUM_W'(30));
        end else if (bin >= SUM_W'(20)) begin
            tens_c = DIGIT_W'(2);
            ones_c = DIGIT_W'(bin - SUM_W'(20));
        end else if (bin >= SUM_W'(10)) begin
            tens_c = DIGIT_W'(1);
            ones_c = DIGIT_W'(bin - SUM_W'(10));
        end
    end

endmodule

// File: rtl/scan_timer.sv
// Slot counter with terminal-count strobe for the display scan FSM.
//   clk, rst_n : clock, async active-low reset
//   clear      : restart counting from 0 on the next edge
//   term       : count value at which the current slot ends
//   done_c     : high during the last cycle of the slot
module scan_timer #(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [CNT_W-1:0] term,
    output logic             done_c
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    assign done_c = (count == term);

endmodule

// File: rtl/seven_segment_decoder.sv
// BCD digit to active-high seven-segment pattern {g,f,e,d,c,b,a}.
//   digit : BCD input (codes above 9 decode to blank)
//   seg_c : active-high segment pattern
module seven_segment_decoder
    import adder_disp_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [SEG_W-1:0]   seg_c
);

    always_comb begin
        seg_c = SEG_OFF;
        case (digit)
            4'd0: seg_c = 7'h3F;
            4'd1: seg_c = 7'h06;
            4'd2: seg_c = 7'h5B;
            4'd3: seg_c = 7'h4F;
            4'd4: seg_c = 7'h66;
            4'd5: seg_c = 7'h6D;
            4'd6: seg_c = 7'h7D;
            4'd7: seg_c = 7'h07;
            4'd8: seg_c = 7'h7F;
            4'd9: seg_c = 7'h6F;
            default: seg_c = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/adder_display_ctrl.sv
// Operand load / sum register plus time-multiplexed 2-digit seven-segment scanner.
//   clk, rst_n      : clock, async active-low reset
//   a, b            : operands, captured when load_valid && load_ready
//   load_valid/ready: operand handshake (one accept every two cycles at most)
//   enable          : display scanning on/off
//   blank_lz        : suppress a zero tens digit
//   seg, an         : registered segment / digit drive (an[0] = ones, an[1] = tens)
//   sum_out         : registered a+b, sum_valid pulses one cycle on update
module adder_display_ctrl
    import adder_disp_pkg::*;
#(
    parameter int unsigned REFRESH_DIV    = 50000,
    parameter int unsigned BLANK_CYCLES   = 250,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic              enable,
    input  logic              blank_lz,
    output logic [SEG_W-1:0]  seg,
    output logic [AN_W-1:0]   an,
    output logic [SUM_W-1:0]  sum_out,
    output logic              sum_valid
);

    localparam int unsigned      CNT_W     = cnt_width(REFRESH_DIV, BLANK_CYCLES);
    localparam bit               HAS_GAP   = (BLANK_CYCLES != 0);
    localparam logic [CNT_W-1:0] SHOW_TERM = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_TERM  = CNT_W'(HAS_GAP ? BLANK_CYCLES - 1 : 0);
    localparam logic [SEG_W-1:0] SEG_IDLE  = SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
    localparam logic [AN_W-1:0]  AN_IDLE   = AN_ACTIVE_LOW ? 2'b11 : 2'b00;

    operand_t           operand_q;
    logic [DIGIT_W-1:0] tens_q, ones_q;
    logic [DIGIT_W-1:0] shadow_tens_q, shadow_ones_q;
    logic [SUM_W-1:0]   sum_c;
    logic [DIGIT_W-1:0] tens_c, ones_c;

    scan_state_e        state_q, state_nxt;
    logic               entering_c;
    logic               timer_clear_c, timer_done_c;
    logic [CNT_W-1:0]   timer_term_c;
    logic [DIGIT_W-1:0] dec_digit_c;
    logic [SEG_W-1:0]   dec_seg_c;
    logic [SEG_W-1:0]   seg_nxt;
    logic [AN_W-1:0]    an_nxt;

    adder u_adder (
        .a     (operand_q.a),
        .b     (operand_q.b),
        .sum_c (sum_c)
    );

    binary_to_bcd u_bcd (
        .bin    (sum_c),
        .tens_c (tens_c),
        .ones_c (ones_c)
    );

    // Load path: capture operands on accept, publish the sum one edge later.
    // load_ready low doubles as the "operands pending" flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            operand_q  <= '0;
            load_ready <= 1'b1;
            sum_out    <= '0;
            sum_valid  <= 1'b0;
            tens_q     <= '0;
            ones_q     <= '0;
        end else begin
            sum_valid <= 1'b0;
            if (!load_ready) begin
                sum_out    <= sum_c;
                tens_q     <= tens_c;
                ones_q     <= ones_c;
                sum_valid  <= 1'b1;
                load_ready <= 1'b1;
            end else if (load_valid) begin
                operand_q  <= '{a: a, b: b};
                load_ready <= 1'b0;
            end
        end
    end

    scan_timer #(.CNT_W(CNT_W)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (timer_clear_c),
        .term   (timer_term_c),
        .done_c (timer_done_c)
    );

    // Scan FSM next state, slot timing and next registered outputs.
    always_comb begin
        state_nxt    = state_q;
        timer_term_c = SHOW_TERM;
        if (state_q == ST_GAP_A || state_q == ST_GAP_B) begin
            timer_term_c = GAP_TERM;
        end

        if (!enable) begin
            state_nxt = ST_OFF;
        end else begin
            case (state_q)
                ST_OFF:       state_nxt = ST_SHOW_ONES;
                ST_SHOW_ONES: if (timer_done_c) state_nxt = HAS_GAP ? ST_GAP_A : ST_SHOW_TENS;
                ST_GAP_A:     if (timer_done_c) state_nxt = ST_SHOW_TENS;
                ST_SHOW_TENS: if (timer_done_c) state_nxt = HAS_GAP ? ST_GAP_B : ST_SHOW_ONES;
                ST_GAP_B:     if (timer_done_c) state_nxt = ST_SHOW_ONES;
                default:      state_nxt = ST_OFF;
            endcase
        end

        timer_clear_c = (state_nxt != state_q) || (state_q == ST_OFF);
        entering_c    = (state_nxt == ST_SHOW_ONES) && (state_q != ST_SHOW_ONES);

        // On frame entry the shadows are being loaded this edge, so decode the
        // source digit directly; otherwise decode the frozen shadow copy.
        if (entering_c) begin
            dec_digit_c = ones_q;
        end else if (state_nxt == ST_SHOW_TENS) begin
            dec_digit_c = shadow_tens_q;
        end else begin
            dec_digit_c = shadow_ones_q;
        end

        seg_nxt = SEG_OFF;
        an_nxt  = '0;
        case (state_nxt)
            ST_SHOW_ONES: begin
                an_nxt  = 2'b01;
                seg_nxt = dec_seg_c;
            end
            ST_SHOW_TENS: begin
                if (!(blank_lz && shadow_tens_q == '0)) begin
                    an_nxt  = 2'b10;
                    seg_nxt = dec_seg_c;
                end
            end
            default: ;
        endcase
        if (SEG_ACTIVE_LOW) seg_nxt = ~seg_nxt;
        if (AN_ACTIVE_LOW)  an_nxt  = ~an_nxt;
    end

    seven_segment_decoder u_dec (
        .digit (dec_digit_c),
        .seg_c (dec_seg_c)
    );

    // Scan state, shadow digits and registered display drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_OFF;
            seg           <= SEG_IDLE;
            an            <= AN_IDLE;
            shadow_tens_q <= '0;
            shadow_ones_q <= '0;
        end else begin
            state_q <= state_nxt;
            seg     <= seg_nxt;
            an      <= an_nxt;
            if (entering_c) begin
                shadow_tens_q <= tens_q;
                shadow_ones_q <= ones_q;
            end
        end
    end

endmodule

// File: tb/tb_adder_display_ctrl.sv
// Self-checking bench for adder_display_ctrl (REFRESH_DIV=4, BLANK_CYCLES=2).
// Sums are scoreboarded with their due cycle; display output is compressed
// into (an, seg, length) runs and compared against an expected run list.
module tb_adder_display_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic       load_valid = 1'b0;
    logic       load_ready;
    logic       enable = 1'b0;
    logic       blank_lz = 1'b0;
    logic [6:0] seg;
    logic [1:0] an;
    logic [4:0] sum_out;
    logic       sum_valid;

    adder_display_ctrl #(
        .REFRESH_DIV  (4),
        .BLANK_CYCLES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a          (a),
        .b          (b),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .enable     (enable),
        .blank_lz   (blank_lz),
        .seg        (seg),
        .an         (an),
        .sum_out    (sum_out),
        .sum_valid  (sum_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Sum scoreboard.
    typedef struct {
        logic [4:0] sum;
        int         due;
    } sum_exp_t;
    sum_exp_t sum_q[$];
    int       pulses = 0;

    always @(negedge clk) begin : sum_mon
        sum_exp_t e;
        if (rst_n && sum_valid) begin
            pulses++;
            if (sum_q.size() == 0) begin
                check("sum_valid_unexpected", 32'(sum_valid), 32'd0);
            end else begin
                e = sum_q.pop_front();
                check("sum_out", 32'(sum_out), 32'(e.sum));
                check("sum_latency", 32'(cyc), 32'(e.due));
            end
        end
    end

    // Display run monitor.
    typedef struct packed {
        logic [1:0]  an;
        logic [6:0]  seg;
        logic [22:0] len;
    } run_t;
    run_t       obs_q[$];
    run_t       exp_q[$];
    bit         mon_on = 1'b0;
    int         skip_runs = 0;
    logic [1:0] cur_an;
    logic [6:0] cur_seg;
    int         cur_len = 0;

    always @(negedge clk) begin
        if (mon_on) begin
            if (cur_len > 0 && an == cur_an && seg == cur_seg) begin
                cur_len++;
            end else begin
                if (cur_len > 0) begin
                    if (skip_runs > 0) skip_runs--;
                    else obs_q.push_back('{an: cur_an, seg: cur_seg, len: 23'(cur_len)});
                end
                cur_an  = an;
                cur_seg = seg;
                cur_len = 1;
            end
        end
    end

    localparam logic [1:0] AN_OFF  = 2'b11;
    localparam logic [1:0] AN_ONES = 2'b10;
    localparam logic [1:0] AN_TENS = 2'b01;
    localparam logic [6:0] S_OFF = 7'h7F;
    localparam logic [6:0] S_0   = 7'b1000000;
    localparam logic [6:0] S_1   = 7'b1111001;
    localparam logic [6:0] S_3   = 7'b0110000;
    localparam logic [6:0] S_5   = 7'b0010010;
    localparam logic [6:0] S_7   = 7'b1111000;

    task automatic exp_run(input logic [1:0] x, input logic [6:0] s, input int l);
        exp_q.push_back('{an: x, seg: s, len: 23'(l)});
    endtask

    task automatic exp_frame(input logic [6:0] ones_seg, input logic [6:0] tens_seg);
        exp_run(AN_ONES, ones_seg, 4);
        exp_run(AN_OFF, S_OFF, 2);
        exp_run(AN_TENS, tens_seg, 4);
        exp_run(AN_OFF, S_OFF, 2);
    endtask

    int cyc0 = 0;

    task automatic wait_until(input int k);
        while (cyc < cyc0 + k) @(negedge clk);
    endtask

    // Offer one operand pair at a negedge; the accept happens on the next edge.
    task automatic load_pair(input logic [3:0] x, input logic [3:0] y);
        int w = 0;
        while (!load_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("load_ready_wait", 32'(load_ready), 32'd1);
        a = x;
        b = y;
        load_valid = 1'b1;
        sum_q.push_back('{sum: 5'(x) + 5'(y), due: cyc + 2});
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int p0;

        // Reset state.
        #12;
        check("rst_an", 32'(an), 32'(AN_OFF));
        check("rst_seg", 32'(seg), 32'(S_OFF));
        check("rst_sum_out", 32'(sum_out), 32'd0);
        check("rst_sum_valid", 32'(sum_valid), 32'd0);
        check("rst_load_ready", 32'(load_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // load_valid held for 6 cycles: accepts on every other cycle.
        p0 = pulses;
        load_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a = 4'((3 * i + 1) & 15);
            b = 4'((5 * i + 7) & 15);
            check($sformatf("hold_ready%0d", i), 32'(load_ready), 32'((i % 2) == 0));
            if ((i % 2) == 0) sum_q.push_back('{sum: 5'(a) + 5'(b), due: cyc + 2});
            @(negedge clk);
        end
        load_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("hold_accepts", 32'(pulses - p0), 32'd3);

        // 9 + 8 = 17 with display off.
        load_pair(4'd9, 4'd8);
        repeat (3) @(negedge clk);
        check("sum17_hold", 32'(sum_out), 32'd17);

        // Display sequence; frame = 12 cycles starting at edge 0 after enable.
        exp_frame(S_7, S_1);                // frame 0: 17 (mid-frame load of 30)
        exp_frame(S_0, S_3);                // frame 1: 30
        exp_frame(S_0, S_3);                // frame 2: 30 (5 lands on entry edge)
        exp_frame(S_5, S_0);                // frame 3: 05, leading zero shown
        exp_run(AN_ONES, S_5, 4);           // frame 4: tens blanked
        exp_run(AN_OFF, S_OFF, 8);
        exp_run(AN_ONES, S_5, 2);           // enable dropped mid-slot
        exp_run(AN_OFF, S_OFF, 4);
        exp_run(AN_ONES, S_5, 4);           // re-enable: full slot

        obs_q.delete();
        cur_len   = 0;
        skip_runs = 1;
        mon_on    = 1'b1;
        cyc0      = cyc;
        enable    = 1'b1;

        wait_until(7);
        load_pair(4'd15, 4'd15);
        wait_until(23);
        load_pair(4'd2, 4'd3);
        wait_until(47);
        blank_lz = 1'b1;
        wait_until(62);
        enable = 1'b0;
        wait_until(63);
        check("disable_an", 32'(an), 32'(AN_OFF));
        check("disable_seg", 32'(seg), 32'(S_OFF));
        wait_until(66);
        enable = 1'b1;
        wait_until(76);
        mon_on = 1'b0;

        check("run_count", 32'(obs_q.size() >= exp_q.size()), 32'd1);
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check($sformatf("run%0d", i), 32'(obs_q[i]), 32'(exp_q[i]));
        end

        // Asynchronous reset in GAP_A with a load pending.
        enable = 1'b0;
        blank_lz = 1'b0;
        repeat (3) @(negedge clk);
        cyc0 = cyc;
        enable = 1'b1;
        wait_until(5);
        a = 4'd7;
        b = 4'd6;
        load_valid = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_an", 32'(an), 32'(AN_OFF));
        check("arst_seg", 32'(seg), 32'(S_OFF));
        check("arst_sum_out", 32'(sum_out), 32'd0);
        check("arst_load_ready", 32'(load_ready), 32'd1);
        check("arst_sum_valid", 32'(sum_valid), 32'd0);
        load_valid = 1'b0;
        enable = 1'b0;
        p0 = pulses;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("post_rst_sum_out", 32'(sum_out), 32'd0);
        check("post_rst_load_ready", 32'(load_ready), 32'd1);
        check("post_rst_pulses", 32'(pulses - p0), 32'd0);
        check("post_rst_an", 32'(an), 32'(AN_OFF));

        check("sb_empty", 32'(sum_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
